// File: rtl/gpzda_frame_controller_pkg.sv
// Shared constants, state encoding and ASCII hex helper for the GPZDA frame controller.
// Holds no logic of its own.
package gpzda_frame_controller_pkg;

    localparam logic [7:0] ASCII_DOLLAR = 8'h24;
    localparam logic [7:0] ASCII_COMMA  = 8'h2C;
    localparam logic [7:0] ASCII_STAR   = 8'h2A;
    localparam logic [7:0] ASCII_CR     = 8'h0D;
    localparam logic [7:0] ASCII_LF     = 8'h0A;

    localparam int              HDR_LEN = 5;
    localparam logic [8*5-1:0]  HDR_STR = "GPZDA";

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_SEP,
        ST_FIELD,
        ST_CS_HI,
        ST_CS_LO
    } state_t;

    typedef struct packed {
        logic       vld;
        logic [3:0] val;
    } hex_nib_t;

    // Uppercase hex only; lowercase digits are treated as invalid.
    function automatic hex_nib_t ascii_hex_nibble(input logic [7:0] c);
        hex_nib_t r;
        r.vld = 1'b0;
        r.val = 4'h0;
        if (c >= 8'h30 && c <= 8'h39) begin
            r.vld = 1'b1;
            r.val = c[3:0];
        end else if (c >= 8'h41 && c <= 8'h46) begin
            r.vld = 1'b1;
            r.val = c[3:0] + 4'd9;
        end
        return r;
    endfunction

endpackage

// File: rtl/gpzda_frame_controller_if.sv
// Byte-in / field-out bundle between the UART receiver, the frame controller and the ZDA decoders.
// master drives bytes and observes fields; slave is the frame controller side.
interface gpzda_frame_controller_if #(parameter int IDX_W = 3);
    logic             load;
    logic [7:0]       data;
    logic             field_valid;
    logic [IDX_W-1:0] field_index;
    logic [7:0]       field_char;
    logic             field_start;
    logic             frame_done;
    logic             checksum_ok;
    logic             frame_error;

    modport master (
        output load, data,
        input  field_valid, field_index, field_char, field_start,
        input  frame_done, checksum_ok, frame_error
    );

    modport slave (
        input  load, data,
        output field_valid, field_index, field_char, field_start,
        output frame_done, checksum_ok, frame_error
    );
endinterface

// File: rtl/gpzda_frame_controller_comparer.sv
// Matches a byte stream against a fixed L-byte reference string.
// Latency: reject/resolve are combinational on the loaded byte; restart wins over load.
// Backpressure: none, one byte per load.
module gpzda_frame_controller_comparer #(
    parameter int             L   = 5,
    parameter logic [8*L-1:0] REF = '0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       restart,
    input  logic       load,
    input  logic [7:0] data,
    output logic       resolve,
    output logic       reject
);
    localparam int POS_W = $clog2(L + 1);

    // Remaining reference bytes, next expected byte in the top slot.
    logic [8*L-1:0]   remain;
    logic [POS_W-1:0] cnt;
    logic             active;
    logic             hit;
    logic             match;

    assign hit     = load && !restart && active;
    assign match   = (data == remain[8*L-1 -: 8]);
    assign reject  = hit && !match;
    assign resolve = hit && match && (cnt == POS_W'(L - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            remain <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (restart) begin
            remain <= REF;
            cnt    <= '0;
            active <= 1'b1;
        end else if (hit) begin
            remain <= remain << 8;
            cnt    <= cnt + 1'b1;
            if (reject || resolve) active <= 1'b0;
        end
    end
endmodule

// File: rtl/gpzda_frame_controller.sv
// Receives one NMEA GPZDA sentence per frame, streams field characters and checks the XOR checksum.
// Latency: every output is registered, 1 cycle after the causing load.
// Backpressure: none, accepts one byte per load strobe.
module gpzda_frame_controller
    import gpzda_frame_controller_pkg::*;
#(
    parameter int N_FIELDS = 6,
    parameter int MAX_LEN  = 82,
    parameter int IDX_W    = 3
) (
    input  logic clock,
    input  logic reset,
    gpzda_frame_controller_if.slave bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 2);

    state_t           state_q, state_n;
    logic [7:0]       xor_q, xor_n;
    logic [LEN_W-1:0] len_q, len_n;
    logic [IDX_W-1:0] idx_q, idx_n;
    logic [3:0]       hi_q, hi_n;
    logic [7:0]       char_q, char_n;
    logic             fv_q, fv_n, fs_q, fs_n;
    logic             done_q, done_n, ok_q, ok_n, err_q, err_n;

    logic       cmp_restart, cmp_load, cmp_resolve, cmp_reject;
    logic [7:0] d;
    hex_nib_t   hx;

    assign d        = bus.data;
    assign hx       = ascii_hex_nibble(d);
    assign cmp_load = bus.load && (state_q == ST_HDR);

    gpzda_frame_controller_comparer #(
        .L   (HDR_LEN),
        .REF (HDR_STR)
    ) u_cmp (
        .clock   (clock),
        .reset   (reset),
        .restart (cmp_restart),
        .load    (cmp_load),
        .data    (d),
        .resolve (cmp_resolve),
        .reject  (cmp_reject)
    );

    always_comb begin
        state_n     = state_q;
        xor_n       = xor_q;
        len_n       = len_q;
        idx_n       = idx_q;
        hi_n        = hi_q;
        char_n      = char_q;
        fv_n        = 1'b0;
        fs_n        = 1'b0;
        done_n      = 1'b0;
        ok_n        = 1'b0;
        err_n       = 1'b0;
        cmp_restart = 1'b0;
        if (bus.load) begin
            if (d == ASCII_DOLLAR) begin
                // Resync from any state, no error reported for the dropped frame.
                state_n     = ST_HDR;
                xor_n       = 8'h00;
                len_n       = LEN_W'(1);
                cmp_restart = 1'b1;
            end else if (state_q != ST_IDLE) begin
                len_n = len_q + 1'b1;
                if (len_q == LEN_W'(MAX_LEN)) begin
                    err_n   = 1'b1;
                    state_n = ST_IDLE;
                end else begin
                    unique case (state_q)
                        ST_HDR: begin
                            xor_n = xor_q ^ d;
                            if (cmp_reject) begin
                                err_n   = 1'b1;
                                state_n = ST_IDLE;
                            end else if (cmp_resolve) begin
                                state_n = ST_SEP;
                            end
                        end
                        ST_SEP: begin
                            if (d == ASCII_COMMA) begin
                                xor_n   = xor_q ^ d;
                                idx_n   = '0;
                                fs_n    = 1'b1;
                                state_n = ST_FIELD;
                            end else begin
                                err_n   = 1'b1;
                                state_n = ST_IDLE;
                            end
                        end
                        ST_FIELD: begin
                            if (d == ASCII_CR || d == ASCII_LF) begin
                                err_n   = 1'b1;
                                state_n = ST_IDLE;
                            end else if (d == ASCII_COMMA) begin
                                if (idx_q < IDX_W'(N_FIELDS - 1)) begin
                                    xor_n = xor_q ^ d;
                                    idx_n = idx_q + 1'b1;
                                    fs_n  = 1'b1;
                                end else begin
                                    err_n   = 1'b1;
                                    state_n = ST_IDLE;
                                end
                            end else if (d == ASCII_STAR) begin
                                if (idx_q == IDX_W'(N_FIELDS - 1)) begin
                                    state_n = ST_CS_HI;
                                end else begin
                                    err_n   = 1'b1;
                                    state_n = ST_IDLE;
                                end
                            end else begin
                                xor_n  = xor_q ^ d;
                                fv_n   = 1'b1;
                                char_n = d;
                            end
                        end
                        ST_CS_HI: begin
                            if (hx.vld) begin
                                hi_n    = hx.val;
                                state_n = ST_CS_LO;
                            end else begin
                                err_n   = 1'b1;
                                state_n = ST_IDLE;
                            end
                        end
                        ST_CS_LO: begin
                            if (hx.vld) begin
                                done_n = 1'b1;
                                ok_n   = ({hi_q, hx.val} == xor_q);
                            end else begin
                                err_n = 1'b1;
                            end
                            state_n = ST_IDLE;
                        end
                        default: state_n = ST_IDLE;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            xor_q   <= 8'h00;
            len_q   <= '0;
            idx_q   <= '0;
            hi_q    <= 4'h0;
            char_q  <= 8'h00;
            fv_q    <= 1'b0;
            fs_q    <= 1'b0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            xor_q   <= xor_n;
            len_q   <= len_n;
            idx_q   <= idx_n;
            hi_q    <= hi_n;
            char_q  <= char_n;
            fv_q    <= fv_n;
            fs_q    <= fs_n;
            done_q  <= done_n;
            ok_q    <= ok_n;
            err_q   <= err_n;
        end
    end

    assign bus.field_valid = fv_q;
    assign bus.field_index = idx_q;
    assign bus.field_char  = char_q;
    assign bus.field_start = fs_q;
    assign bus.frame_done  = done_q;
    assign bus.checksum_ok = ok_q;
    assign bus.frame_error = err_q;
endmodule

// File: tb/tb_gpzda_frame_controller.sv
// Bench for gpzda_frame_controller: directed sentences plus randomized frames,
// each byte checked against a text-prefix parser of the sentence received so far.
module tb_gpzda_frame_controller;
    localparam int N_FIELDS = 6;
    localparam int MAX_LEN  = 82;
    localparam int IDX_W    = 3;

    logic clock;
    logic reset;

    gpzda_frame_controller_if #(.IDX_W(IDX_W)) bus();

    gpzda_frame_controller #(
        .N_FIELDS (N_FIELDS),
        .MAX_LEN  (MAX_LEN),
        .IDX_W    (IDX_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Model state: bytes of the frame in progress, starting with '$'; empty while hunting.
    logic [7:0] frm [$];
    string      hdr = "GPZDA";
    logic       e_fv, e_fs, e_done, e_ok, e_err;
    int         e_idx;
    logic [7:0] e_char;

    // Observations taken from the DUT for the directed scenarios.
    string fld [0:7];
    int    n_fv, n_done, n_ok, n_err;

    string good = "$GPZDA,201530.00,04,07,2002,00,00*60";

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_hex(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46);
    endfunction

    function automatic logic [3:0] hexval(input logic [7:0] c);
        return (c <= 8'h39) ? 4'(c - 8'h30) : 4'(c - 8'h37);
    endfunction

    task automatic model_fail();
        e_err = 1'b1;
        frm.delete();
    endtask

    task automatic model_step(input logic [7:0] b);
        int n, commas, star;
        logic [7:0] x;
        e_fv = 0; e_fs = 0; e_done = 0; e_ok = 0; e_err = 0;
        if (b == 8'h24) begin
            frm.delete();
            frm.push_back(b);
            return;
        end
        if (frm.size() == 0) return;
        n = frm.size() + 1;
        if (n > MAX_LEN) begin model_fail(); return; end
        if (n <= 6) begin
            if (b != hdr[n-2]) model_fail(); else frm.push_back(b);
            return;
        end
        if (n == 7) begin
            if (b != 8'h2C) model_fail();
            else begin frm.push_back(b); e_fs = 1; e_idx = 0; end
            return;
        end
        commas = 0; star = -1;
        foreach (frm[i]) begin
            if (frm[i] == 8'h2C) commas++;
            if (frm[i] == 8'h2A) star = i;
        end
        if (star < 0) begin
            if (b == 8'h0D || b == 8'h0A) model_fail();
            else if (b == 8'h2C) begin
                if (commas < N_FIELDS) begin frm.push_back(b); e_fs = 1; e_idx = commas; end
                else model_fail();
            end else if (b == 8'h2A) begin
                if (commas == N_FIELDS) frm.push_back(b); else model_fail();
            end else begin
                frm.push_back(b); e_fv = 1; e_idx = commas - 1; e_char = b;
            end
        end else if (!is_hex(b)) begin
            model_fail();
        end else if (frm.size() - star == 1) begin
            frm.push_back(b);
        end else begin
            x = 8'h00;
            for (int i = 1; i < star; i++) x ^= frm[i];
            e_done = 1;
            e_ok   = ({hexval(frm[star+1]), hexval(b)} == x);
            frm.delete();
        end
    endtask

    task automatic compare_outputs(input string tag);
        check({tag, ".fv"},   32'(bus.field_valid), 32'(e_fv));
        check({tag, ".fs"},   32'(bus.field_start), 32'(e_fs));
        check({tag, ".done"}, 32'(bus.frame_done),  32'(e_done));
        check({tag, ".ok"},   32'(bus.checksum_ok), 32'(e_ok));
        check({tag, ".err"},  32'(bus.frame_error), 32'(e_err));
        if (e_fv || e_fs) check({tag, ".idx"}, 32'(bus.field_index), 32'(e_idx));
        if (e_fv)         check({tag, ".chr"}, 32'(bus.field_char),  32'(e_char));
        if (bus.field_valid) begin
            n_fv++;
            fld[bus.field_index] = $sformatf("%s%c", fld[bus.field_index], bus.field_char);
        end
        if (bus.frame_done)  n_done++;
        if (bus.checksum_ok) n_ok++;
        if (bus.frame_error) n_err++;
    endtask

    task automatic begin_obs();
        n_fv = 0; n_done = 0; n_ok = 0; n_err = 0;
        for (int i = 0; i < 8; i++) fld[i] = "";
    endtask

    task automatic send(input logic [7:0] b, input int gap, input string tag);
        @(negedge clock);
        bus.load = 1'b1;
        bus.data = b;
        model_step(b);
        @(posedge clock);
        #1;
        compare_outputs(tag);
        bus.load = 1'b0;
        for (int g = 0; g < gap; g++) begin
            e_fv = 0; e_fs = 0; e_done = 0; e_ok = 0; e_err = 0;
            @(posedge clock);
            #1;
            compare_outputs({tag, ".gap"});
        end
    endtask

    task automatic send_str(input string s, input int gap, input string tag);
        for (int i = 0; i < s.len(); i++) send(s[i], gap, tag);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".fv"},   32'(bus.field_valid), 0);
        check({tag, ".fs"},   32'(bus.field_start), 0);
        check({tag, ".idx"},  32'(bus.field_index), 0);
        check({tag, ".chr"},  32'(bus.field_char),  0);
        check({tag, ".done"}, 32'(bus.frame_done),  0);
        check({tag, ".ok"},   32'(bus.checksum_ok), 0);
        check({tag, ".err"},  32'(bus.frame_error), 0);
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clock);
        reset    = 1'b1;
        bus.load = 1'b1;
        bus.data = 8'h24;
        @(posedge clock);
        #1;
        check_quiet(tag);
        frm.delete();
        @(negedge clock);
        reset    = 1'b0;
        bus.load = 1'b0;
    endtask

    function automatic string make_sentence(input bit good_cs);
        string s;
        logic [7:0] x;
        s = "GPZDA";
        for (int f = 0; f < N_FIELDS; f++) begin
            s = {s, ","};
            for (int k = int'($urandom_range(0, 4)); k > 0; k--)
                s = $sformatf("%s%0d", s, $urandom_range(0, 9));
        end
        x = 8'h00;
        for (int i = 0; i < s.len(); i++) x ^= s[i];
        if (!good_cs) x = 8'($urandom_range(0, 255));
        return $sformatf("$%s*%02X", s, x);
    endfunction

    initial begin
        #5000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pool [8];
        string s;
        pool = '{8'h2C, 8'h2A, 8'h24, 8'h61, 8'h0D, 8'h5A, 8'h39, 8'h46};
        reset    = 1'b1;
        bus.load = 1'b0;
        bus.data = 8'h00;
        begin_obs();
        repeat (3) @(posedge clock);
        #1;
        check_quiet("reset");
        @(negedge clock);
        reset = 1'b0;

        begin_obs();
        send_str(good, 0, "good");
        check("good.f0",   32'(fld[0] == "201530.00"), 1);
        check("good.f2",   32'(fld[2] == "07"), 1);
        check("good.f3",   32'(fld[3] == "2002"), 1);
        check("good.ndone", n_done, 1);
        check("good.nok",   n_ok, 1);
        check("good.nerr",  n_err, 0);

        begin_obs();
        send_str("$GPZDA,201530.00,04,07,2002,00,00*61", 0, "badcs");
        check("badcs.ndone", n_done, 1);
        check("badcs.nok",   n_ok, 0);

        begin_obs();
        send_str("$GPRMC,201530.00,04*60", 0, "rmc");
        check("rmc.nerr", n_err, 1);
        check("rmc.nfv",  n_fv, 0);

        begin_obs();
        send_str("$GPZDA,1,2,3,4,5,6,7*00", 0, "comma7");
        check("comma7.nerr",  n_err, 1);
        check("comma7.ndone", n_done, 0);

        begin_obs();
        send_str("$GPZDA,1,2*00", 0, "star2");
        check("star2.nerr", n_err, 1);

        begin_obs();
        send_str({"$GPZD", good}, 0, "resync");
        check("resync.nerr",  n_err, 0);
        check("resync.ndone", n_done, 1);
        check("resync.nok",   n_ok, 1);

        begin_obs();
        send_str({"$GPZD", good}, 5, "gap");
        check("gap.nerr",  n_err, 0);
        check("gap.ndone", n_done, 1);
        check("gap.nok",   n_ok, 1);
        check("gap.f0",    32'(fld[0] == "201530.00"), 1);

        begin_obs();
        send_str("$GPZDA,", 0, "long");
        for (int i = 0; i < 90; i++) send(8'h31, 0, "long");
        check("long.nerr", n_err, 1);
        check("long.nfv",  n_fv, MAX_LEN - 7);

        send_str("$GPZDA,12", 0, "midrst");
        apply_reset("midrst");
        begin_obs();
        send_str(good, 0, "postrst");
        check("postrst.ndone", n_done, 1);
        check("postrst.nok",   n_ok, 1);
        check("postrst.nerr",  n_err, 0);

        for (int t = 0; t < 60; t++) begin
            s = make_sentence($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0)
                s.putc(int'($urandom_range(1, s.len() - 1)), pool[$urandom_range(0, 7)]);
            if ($urandom_range(0, 4) == 0) send(8'($urandom_range(32, 126)), 0, "noise");
            send_str(s, int'($urandom_range(0, 1)), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
